demux1to4_reg: RTL and testbench

//   Registered 1-to-4 demultiplexer: the distribution counterpart of the 4:1 select mux.
//   - Accepts WIDTH-bit beats on one valid/ready input.
//   - Routes each beat to one of four valid/ready output channels chosen by in_sel.
//   - Each channel holds its beat in a 1-deep output register until the consumer takes it.
//   - Sits between a single producer and four independent consumers (lab datapath fan-out).

---
 rtl/demux1to4_reg.sv | 95 +++++++++
 tb/tb_demux1to4_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 valid/ready demultiplexer with a 1-deep holding register per channel.
// Optional feature: define DEMUX_RR_EN to route beats round-robin instead of by in_sel.
module demux1to4_reg #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [1:0]           cur_dest,
    output logic [CNT_WIDTH-1:0] beat_cnt
);

    logic [1:0]           dest_s;
    logic                 accept_s;
    logic [3:0]           load_s;
    logic [3:0]           valid_nxt_s;
    logic [4*WIDTH-1:0]   data_r;
    logic [3:0]           valid_r;
    logic [CNT_WIDTH-1:0] cnt_r;

`ifdef DEMUX_RR_EN
    logic [1:0] rr_ptr_r;

    // Round-robin pointer: advances only when a beat is actually accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= 2'd0;
        end else if (accept_s) begin
            rr_ptr_r <= rr_ptr_r + 2'd1;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign dest_s = rr_ptr_r;
`else
    assign dest_s = in_sel;
`endif

    assign cur_dest = dest_s;
    // A full channel still accepts when its consumer empties it on the same edge.
    assign in_ready = !valid_r[dest_s] | out_ready[dest_s];
    assign accept_s = in_valid & in_ready;

    // Per-channel load strobe and next valid state (load wins over drain).
    always_comb begin
        load_s      = 4'b0000;
        valid_nxt_s = valid_r;
        for (int k = 0; k < 4; k++) begin
            if (accept_s && (dest_s == k[1:0])) begin
                load_s[k]      = 1'b1;
                valid_nxt_s[k] = 1'b1;
            end else if (valid_r[k] && out_ready[k]) begin
                valid_nxt_s[k] = 1'b0;
            end else begin
                valid_nxt_s[k] = valid_r[k];
            end
        end
    end

    // Channel holding registers and accepted-beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 4'b0000;
            data_r  <= '0;
            cnt_r   <= '0;
        end else begin
            valid_r <= valid_nxt_s;
            for (int k = 0; k < 4; k++) begin
                if (load_s[k]) begin
                    data_r[k*WIDTH +: WIDTH] <= in_data;
                end else begin
                    data_r[k*WIDTH +: WIDTH] <= data_r[k*WIDTH +: WIDTH];
                end
            end
            if (accept_s) begin
                cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign beat_cnt  = cnt_r;

endmodule

// File: tb/tb_demux1to4_reg.sv
// Scoreboard bench for demux1to4_reg: stimulus pushes expected beats per channel,
// a negedge monitor pops and compares every beat a consumer takes.
module tb_demux1to4_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [1:0]  cur_dest;
    logic [7:0]  beat_cnt;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_cnt;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q3[$];

    demux1to4_reg #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .cur_dest(cur_dest),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        case (k)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic take(input int k, input logic [7:0] act);
        logic [7:0] e;
        if (qsize(k) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_take ch%0d: got %0h expected no beat", k, act);
        end else begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            chk($sformatf("take_ch%0d", k), {24'h0, act}, {24'h0, e});
        end
    endtask

    // Monitor: a beat is taken on the next rising edge whenever valid & ready.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) take(k, out_data[k*8 +: 8]);
            end
        end
    end

    // Present a beat; ch is the channel the bench expects it to land in.
    task automatic send(input int ch, input logic [1:0] s, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        in_sel = s; in_data = d; in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (ok) begin
            push(ch, d);
            exp_cnt = exp_cnt + 8'd1;
        end else begin
            checks++; errors++;
            $display("FAIL send_timeout ch%0d: got in_ready=0 expected 1", ch);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        exp_cnt = 8'd0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_data = 8'h00; in_sel = 2'd0; in_valid = 1'b0; out_ready = 4'b0000;
        exp_cnt = 8'd0;
        idle(2);
        chk("reset_valid", {28'h0, out_valid}, 32'h0);
        chk("reset_data", out_data, 32'h0);
        chk("reset_cnt", {24'h0, beat_cnt}, 32'h0);
        reset = 1'b0;
        idle(1);

`ifdef DEMUX_RR_EN
        // Round-robin: in_sel held at 0, beats land on 0,1,2,3,0.
        out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) send(i % 4, 2'd0, 8'(i + 1));
        chk("rr_cnt5", {24'h0, beat_cnt}, 32'd5);
        out_ready = 4'b1101;
        for (int i = 0; i < 4; i++) send((i + 1) % 4, 2'd0, 8'h60 + 8'(i));
        in_sel = 2'd0; in_data = 8'h99; in_valid = 1'b1; #1;
        chk("rr_stall_dest", {30'h0, cur_dest}, 32'd1);
        chk("rr_stall_ready", {31'h0, in_ready}, 32'd0);
        idle(1);
        chk("rr_stall_hold", {30'h0, cur_dest}, 32'd1);
        in_valid = 1'b0;
        out_ready = 4'b1111;
        idle(1);
        send(1, 2'd0, 8'h99);
        idle(2);
`else
        // Directed routing by in_sel.
        send(2, 2'd2, 8'hA5);
        chk("t1_valid", {28'h0, out_valid}, 32'h4);
        chk("t1_ch2", {24'h0, out_data[23:16]}, 32'hA5);
        chk("t1_cnt", {24'h0, beat_cnt}, 32'd1);

        send(1, 2'd1, 8'h3C);
        in_sel = 2'd1; in_data = 8'h77; in_valid = 1'b1; #1;
        chk("t2_full_ready", {31'h0, in_ready}, 32'd0);
        chk("t2_cur_dest", {30'h0, cur_dest}, 32'd1);
        idle(1);
        chk("t2_ch1_hold", {24'h0, out_data[15:8]}, 32'h3C);
        chk("t2_cnt_hold", {24'h0, beat_cnt}, 32'd2);
        in_valid = 1'b0;
        send(3, 2'd3, 8'h5A);
        chk("t2_valid", {28'h0, out_valid}, 32'hE);
        out_ready = 4'b1111;
        idle(2);
        chk("t2_drained", {28'h0, out_valid}, 32'h0);

        for (int i = 0; i < 8; i++) send(i % 4, 2'(i), 8'h40 + 8'(i));
        idle(2);
        chk("t3_drained", {28'h0, out_valid}, 32'h0);
        chk("t3_cnt", {24'h0, beat_cnt}, {24'h0, exp_cnt});

        send(0, 2'd0, 8'h11);
        chk("t4_v1", {31'h0, out_valid[0]}, 32'd1);
        chk("t4_d1", {24'h0, out_data[7:0]}, 32'h11);
        send(0, 2'd0, 8'h22);
        chk("t4_v2", {31'h0, out_valid[0]}, 32'd1);
        chk("t4_d2", {24'h0, out_data[7:0]}, 32'h22);
        idle(2);
        chk("t4_kept", {24'h0, out_data[7:0]}, 32'h22);
`endif

        // Counter wrap after 256 accepts from reset.
        do_reset();
        out_ready = 4'b1111;
        for (int i = 0; i < 256; i++) send(i % 4, 2'(i), 8'(i ^ 8'h5C));
        chk("t5_wrap", {24'h0, beat_cnt}, 32'h0);
        idle(2);
        chk("t5_no_drop", qsize(0) + qsize(1) + qsize(2) + qsize(3), 32'd0);

        // Asynchronous reset with three channels full.
        out_ready = 4'b0000;
        for (int i = 0; i < 3; i++) send(i, 2'(i), 8'hC0 + 8'(i));
        chk("t5_full", {28'h0, out_valid}, 32'h7);
        @(negedge clk); #2;
        reset = 1'b1; #1;
        chk("t5_async_valid", {28'h0, out_valid}, 32'h0);
        chk("t5_async_cnt", {24'h0, beat_cnt}, 32'h0);
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hEE;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        idle(1);
        chk("t5_no_accept_in_reset", {24'h0, beat_cnt}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
